// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, MUL FSM states,
// default widths and the control bundle carried across a multi-cycle MUL.
package ex_pkg;
    localparam int DW_DEF  = 32;
    localparam int SHW_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } ex_state_e;

    typedef struct packed {
        logic rf_wre;
        logic dm_wre;
        logic m2sele;
        logic m3sele;
    } ctl_t;
endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled with the stall line.
interface ex_stage_if #(parameter int DW = 32);
    logic          rf_wre;
    logic          dm_wre;
    logic          m1sele;
    logic          m2sele;
    logic          m3sele;
    logic [2:0]    ALUope;
    logic [DW-1:0] exte;
    logic [DW-1:0] rsE;
    logic [DW-1:0] rtE;
    logic [DW-1:0] rdE;

    logic          rf_wrm;
    logic          dm_wrm;
    logic          m2selm;
    logic          m3selm;
    logic [DW-1:0] alu_outm;
    logic [DW-1:0] rtM;
    logic [DW-1:0] rdM;
    logic          zerom;
    logic          stall;

    modport master (
        output rf_wre, dm_wre, m1sele, m2sele, m3sele, ALUope, exte, rsE, rtE, rdE,
        input  rf_wrm, dm_wrm, m2selm, m3selm, alu_outm, rtM, rdM, zerom, stall
    );

    modport slave (
        input  rf_wre, dm_wre, m1sele, m2sele, m3sele, ALUope, exte, rsE, rtE, rdE,
        output rf_wrm, dm_wrm, m2selm, m3selm, alu_outm, rtM, rdM, zerom, stall
    );
endinterface

// File: rtl/ex_alu.sv
// Single-cycle ALU for every opcode except MUL, which the top handles iteratively.
module ex_alu
    import ex_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: y = a << b[SHW-1:0];
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, single-cycle ALU, DW-step shift-add multiplier
// and the EX/MEM register. Stall holds upstream for the whole MUL.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic       clk,
    input  logic       s,
    ex_stage_if.slave  bus
);
    ex_state_e     state, state_nxt;
    logic          stall_int;
    logic [DW-1:0] b_op;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_step;
    logic [SHW-1:0] cnt;
    logic          last_step;
    logic          is_mul;
    ctl_t          ctl_in;
    ctl_t          ctl_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] rd_q;

    assign b_op      = bus.m1sele ? bus.exte : bus.rtE;
    assign is_mul    = (bus.ALUope == ALU_MUL);
    assign last_step = (cnt == SHW'(DW-1));
    assign acc_step  = mul_b[0] ? (acc + mul_a) : acc;
    assign ctl_in    = {bus.rf_wre, bus.dm_wre, bus.m2sele, bus.m3sele};

    ex_alu #(.DW(DW), .SHW(SHW)) u_alu (
        .a  (bus.rsE),
        .b  (b_op),
        .op (bus.ALUope),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge s) begin
        if (!s) state <= IDLE;
        else    state <= state_nxt;
    end

    // Stall covers the IDLE accept cycle plus DW-1 MUL cycles; the last step
    // drops it so upstream advances on the same edge the result is written.
    always_comb begin
        state_nxt = state;
        stall_int = 1'b0;
        case (state)
            IDLE: begin
                if (is_mul) begin
                    state_nxt = MUL;
                    stall_int = 1'b1;
                end
            end
            MUL: begin
                stall_int = !last_step;
                if (last_step) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        bus.stall = s & stall_int;
    end

    always_ff @(posedge clk or negedge s) begin
        if (!s) begin
            mul_a        <= '0;
            mul_b        <= '0;
            acc          <= '0;
            cnt          <= '0;
            ctl_q        <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            bus.rf_wrm   <= 1'b0;
            bus.dm_wrm   <= 1'b0;
            bus.m2selm   <= 1'b0;
            bus.m3selm   <= 1'b0;
            bus.alu_outm <= '0;
            bus.rtM      <= '0;
            bus.rdM      <= '0;
            bus.zerom    <= 1'b0;
        end else if (state == IDLE) begin
            if (!is_mul) begin
                bus.rf_wrm   <= bus.rf_wre;
                bus.dm_wrm   <= bus.dm_wre;
                bus.m2selm   <= bus.m2sele;
                bus.m3selm   <= bus.m3sele;
                bus.alu_outm <= alu_y;
                bus.rtM      <= bus.rtE;
                bus.rdM      <= bus.rdE;
                bus.zerom    <= (alu_y == '0);
            end else begin
                mul_a      <= bus.rsE;
                mul_b      <= b_op;
                ctl_q      <= ctl_in;
                rt_q       <= bus.rtE;
                rd_q       <= bus.rdE;
                cnt        <= '0;
                acc        <= '0;
                bus.rf_wrm <= 1'b0;
                bus.dm_wrm <= 1'b0;
            end
        end else begin
            acc   <= acc_step;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + SHW'(1);
            if (last_step) begin
                bus.rf_wrm   <= ctl_q.rf_wre;
                bus.dm_wrm   <= ctl_q.dm_wre;
                bus.m2selm   <= ctl_q.m2sele;
                bus.m3selm   <= ctl_q.m3sele;
                bus.alu_outm <= acc_step;
                bus.rtM      <= rt_q;
                bus.rdM      <= rd_q;
                bus.zerom    <= (acc_step == '0);
            end else begin
                bus.rf_wrm <= 1'b0;
                bus.dm_wrm <= 1'b0;
            end
        end
    end
endmodule
